// File: rtl/dcache_pkg.sv
// Shared constants and byte-lane helpers for the Dcache dual-port block RAM.
package dcache_pkg;

   localparam int LAT_1           = 1;
   localparam int LAT_2           = 2;
   localparam int RDW_READ_FIRST  = 0;
   localparam int RDW_WRITE_FIRST = 1;

   // Widest word merge_bytes handles; callers zero-extend and truncate.
   localparam int MERGE_W  = 1024;
   localparam int MERGE_NB = MERGE_W / 8;

   function automatic logic [MERGE_W-1:0] merge_bytes(
      input logic [MERGE_W-1:0]  old_word,
      input logic [MERGE_W-1:0]  new_word,
      input logic [MERGE_NB-1:0] be
   );
      logic [MERGE_W-1:0] res;
      res = old_word;
      for (int i = 0; i < MERGE_NB; i++) begin
         if (be[i]) res[i*8 +: 8] = new_word[i*8 +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/dcache_bram_rdpipe.sv
// Per-port read return path: optional output register, rvalid tracking and
// hold-last-value behaviour so dout stays stable between reads.
module dcache_bram_rdpipe
   import dcache_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int OUT_REG    = 0
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  req_vld_i,
   input  logic [DATA_WIDTH-1:0] req_data_i,
   output logic [DATA_WIDTH-1:0] dout_o,
   output logic                  rvalid_o
);

   localparam int LATENCY = (OUT_REG != 0) ? LAT_2 : LAT_1;

   generate
      if (LATENCY == LAT_2) begin : g_out_reg
         logic [DATA_WIDTH-1:0] out_q;
         logic                  vld_q;

         // Output register only loads on a returned read, so it doubles as the hold.
         always_ff @(posedge clk) begin
            if (!rstn) begin
               out_q <= '0;
               vld_q <= 1'b0;
            end else begin
               vld_q <= req_vld_i;
               if (req_vld_i) out_q <= req_data_i;
            end
         end

         assign dout_o   = out_q;
         assign rvalid_o = vld_q;
      end else begin : g_no_out_reg
         logic [DATA_WIDTH-1:0] hold_q;

         always_ff @(posedge clk) begin
            if (!rstn) begin
               hold_q <= '0;
            end else if (req_vld_i) begin
               hold_q <= req_data_i;
            end
         end

         assign dout_o   = req_vld_i ? req_data_i : hold_q;
         assign rvalid_o = req_vld_i;
      end
   endgenerate

endmodule

// File: rtl/dcache_bram_dp.sv
// Dcache dual-port block RAM: port A read/write with byte enables, port B
// read-only, explicit read-during-write and cross-port forwarding.
module dcache_bram_dp
   import dcache_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 8,
   parameter int OUT_REG    = 0,
   parameter int RDW_MODE   = 1
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic                    ena,
   input  logic [DATA_WIDTH/8-1:0] wea,
   input  logic [ADDR_WIDTH-1:0]   addra,
   input  logic [DATA_WIDTH-1:0]   dina,
   output logic [DATA_WIDTH-1:0]   douta,
   output logic                    rvalida,
   input  logic                    enb,
   input  logic [ADDR_WIDTH-1:0]   addrb,
   output logic [DATA_WIDTH-1:0]   doutb,
   output logic                    rvalidb
);

   localparam int NB    = DATA_WIDTH / 8;
   localparam int DEPTH = 2 ** ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] rd_a;
   logic [DATA_WIDTH-1:0] rd_b;

   // One RAM per byte lane keeps byte-enable writes a plain per-lane write port.
   generate
      for (genvar gi = 0; gi < NB; gi++) begin : g_lane
         logic [7:0] mem_lane [DEPTH];
         logic [7:0] rd_a_q;
         logic [7:0] rd_b_q;

         always_ff @(posedge clk) begin
            if (rstn && ena && wea[gi]) mem_lane[addra] <= dina[gi*8 +: 8];
            rd_a_q <= mem_lane[addra];
            rd_b_q <= mem_lane[addrb];
         end

         assign rd_a[gi*8 +: 8] = rd_a_q;
         assign rd_b[gi*8 +: 8] = rd_b_q;
      end
   endgenerate

   logic                  va_q, vb_q;
   logic                  fwdb_q, fwdb_d;
   logic [NB-1:0]         be_q, be_d;
   logic [DATA_WIDTH-1:0] wd_q;

   always_comb begin
      be_d   = ena ? wea : '0;
      fwdb_d = ena && enb && (addra == addrb) && (wea != '0);
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         va_q   <= 1'b0;
         vb_q   <= 1'b0;
         fwdb_q <= 1'b0;
         be_q   <= '0;
         wd_q   <= '0;
      end else begin
         va_q   <= ena;
         vb_q   <= enb;
         fwdb_q <= fwdb_d;
         be_q   <= be_d;
         wd_q   <= dina;
      end
   end

   logic [DATA_WIDTH-1:0] merged_a, merged_b;
   logic [DATA_WIDTH-1:0] data_a, data_b;

   // The array returns the pre-write word; write-first overlays the captured write bytes.
   always_comb begin
      merged_a = DATA_WIDTH'(merge_bytes(MERGE_W'(rd_a), MERGE_W'(wd_q), MERGE_NB'(be_q)));
      merged_b = DATA_WIDTH'(merge_bytes(MERGE_W'(rd_b), MERGE_W'(wd_q), MERGE_NB'(be_q)));
      data_a   = (RDW_MODE == RDW_WRITE_FIRST) ? merged_a : rd_a;
      data_b   = ((RDW_MODE == RDW_WRITE_FIRST) && fwdb_q) ? merged_b : rd_b;
   end

   dcache_bram_rdpipe #(
      .DATA_WIDTH(DATA_WIDTH),
      .OUT_REG   (OUT_REG)
   ) u_pipe_a (
      .clk       (clk),
      .rstn      (rstn),
      .req_vld_i (va_q),
      .req_data_i(data_a),
      .dout_o    (douta),
      .rvalid_o  (rvalida)
   );

   dcache_bram_rdpipe #(
      .DATA_WIDTH(DATA_WIDTH),
      .OUT_REG   (OUT_REG)
   ) u_pipe_b (
      .clk       (clk),
      .rstn      (rstn),
      .req_vld_i (vb_q),
      .req_data_i(data_b),
      .dout_o    (doutb),
      .rvalid_o  (rvalidb)
   );

endmodule

// File: tb/tb_dcache_bram_dp.sv
// Bench for dcache_bram_dp: all four OUT_REG/RDW_MODE builds share one stimulus
// stream and are compared against a transaction-level memory model.
module tb_dcache_bram_dp;

   localparam int DW   = 32;
   localparam int AW   = 8;
   localparam int NCFG = 4;   // cfg c: RDW_MODE = c%2, OUT_REG = c/2

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rstn, ena, enb;
   logic [3:0]    wea;
   logic [AW-1:0] addra, addrb;
   logic [DW-1:0] dina;

   logic [DW-1:0] douta_w [NCFG];
   logic [DW-1:0] doutb_w [NCFG];
   logic          rvalida_w [NCFG];
   logic          rvalidb_w [NCFG];

   generate
      for (genvar gi = 0; gi < NCFG; gi++) begin : g_dut
         dcache_bram_dp #(
            .DATA_WIDTH(DW),
            .ADDR_WIDTH(AW),
            .OUT_REG   (gi / 2),
            .RDW_MODE  (gi % 2)
         ) u_dut (
            .clk    (clk),
            .rstn   (rstn),
            .ena    (ena),
            .wea    (wea),
            .addra  (addra),
            .dina   (dina),
            .douta  (douta_w[gi]),
            .rvalida(rvalida_w[gi]),
            .enb    (enb),
            .addrb  (addrb),
            .doutb  (doutb_w[gi]),
            .rvalidb(rvalidb_w[gi])
         );
      end
   endgenerate

   typedef struct {
      bit            v;
      logic [DW-1:0] d;
   } item_t;

   logic [DW-1:0] ref_mem [2**AW];
   item_t         pipe  [NCFG][2][2];   // cfg, port, age (0 = newest)
   logic [DW-1:0] hold  [NCFG][2];
   logic [DW-1:0] exp_d [NCFG][2];
   bit            exp_v [NCFG][2];

   int vectors    = 0;
   int miscompares = 0;
   bit chk_on     = 1'b0;

   function automatic logic [DW-1:0] overlay(input logic [DW-1:0] old_w,
                                             input logic [DW-1:0] new_w,
                                             input logic [3:0]    be);
      logic [DW-1:0] r;
      r = old_w;
      for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
      return r;
   endfunction

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
      vectors++;
      if (obs !== expv) begin
         miscompares++;
         $display("FAIL %s: got %08h want %08h", tag, obs, expv);
      end
   endtask

   // Model one clock edge from the current inputs, then check every build.
   task automatic tick();
      item_t nw [2][2];   // rdw mode, port
      item_t o;
      for (int m = 0; m < 2; m++) begin
         nw[m][0].v = rstn && ena;
         nw[m][0].d = (m == 1) ? overlay(ref_mem[addra], dina, wea) : ref_mem[addra];
         nw[m][1].v = rstn && enb;
         nw[m][1].d = (m == 1 && ena && addra == addrb) ? overlay(ref_mem[addrb], dina, wea)
                                                       : ref_mem[addrb];
      end
      if (rstn && ena) ref_mem[addra] = overlay(ref_mem[addra], dina, wea);
      for (int c = 0; c < NCFG; c++) begin
         for (int p = 0; p < 2; p++) begin
            if (!rstn) begin
               pipe[c][p][0] = '{v: 1'b0, d: '0};
               pipe[c][p][1] = '{v: 1'b0, d: '0};
               hold[c][p]    = '0;
               exp_v[c][p]   = 1'b0;
               exp_d[c][p]   = '0;
            end else begin
               pipe[c][p][1] = pipe[c][p][0];
               pipe[c][p][0] = nw[c % 2][p];
               o = (c / 2 == 0) ? pipe[c][p][0] : pipe[c][p][1];
               exp_v[c][p] = o.v;
               if (o.v) hold[c][p] = o.d;
               exp_d[c][p] = hold[c][p];
            end
         end
      end
      @(posedge clk);
      #1;
      if (chk_on) begin
         for (int c = 0; c < NCFG; c++) begin
            chk($sformatf("cfg%0d douta", c), douta_w[c], exp_d[c][0]);
            chk($sformatf("cfg%0d rvalida", c), {31'b0, rvalida_w[c]}, {31'b0, exp_v[c][0]});
            chk($sformatf("cfg%0d doutb", c), doutb_w[c], exp_d[c][1]);
            chk($sformatf("cfg%0d rvalidb", c), {31'b0, rvalidb_w[c]}, {31'b0, exp_v[c][1]});
         end
      end
   endtask

   task automatic cyc(input bit ea, input logic [3:0] be, input logic [AW-1:0] aa,
                      input logic [DW-1:0] da, input bit eb, input logic [AW-1:0] ab);
      ena = ea; wea = be; addra = aa; dina = da; enb = eb; addrb = ab;
      tick();
   endtask

   initial begin
      logic [AW-1:0] ra, rb;
      rstn = 1'b0;
      cyc(0, 4'h0, 8'h00, 32'h0, 0, 8'h00);
      cyc(0, 4'h0, 8'h00, 32'h0, 0, 8'h00);
      rstn = 1'b1;

      // Fill every word so the model never predicts from unknown contents.
      for (int i = 0; i < 2**AW; i++) cyc(1, 4'hF, AW'(i), $urandom, 0, 8'h00);

      chk_on = 1'b1;
      rstn = 1'b0;
      cyc(1, 4'hF, 8'h40, 32'h12345678, 1, 8'h41);
      cyc(0, 4'h0, 8'h00, 32'h0, 0, 8'h00);
      chk("reset doutb", doutb_w[3], 32'h0);
      rstn = 1'b1;

      // Write then read on both ports.
      cyc(1, 4'hF, 8'h10, 32'hDEADBEEF, 0, 8'h00);
      cyc(1, 4'h0, 8'h10, 32'h0, 1, 8'h10);
      chk("wr_rd lat1 douta", douta_w[0], 32'hDEADBEEF);
      chk("wr_rd lat1 doutb", doutb_w[1], 32'hDEADBEEF);
      cyc(0, 4'h0, 8'h00, 32'h0, 0, 8'h00);
      chk("wr_rd lat2 doutb", doutb_w[2], 32'hDEADBEEF);
      chk("wr_rd lat2 rvalidb", {31'b0, rvalidb_w[2]}, 32'h1);

      // Cross-port collision with partial byte enables.
      cyc(1, 4'hF, 8'h20, 32'h11223344, 0, 8'h00);
      cyc(1, 4'b0101, 8'h20, 32'hAABBCCDD, 1, 8'h20);
      chk("collide wf doutb", doutb_w[1], 32'h11BB33DD);
      chk("collide rf doutb", doutb_w[0], 32'h11223344);
      cyc(0, 4'h0, 8'h00, 32'h0, 1, 8'h20);
      chk("collide wf lat2 doutb", doutb_w[3], 32'h11BB33DD);
      chk("collide rf lat2 doutb", doutb_w[2], 32'h11223344);
      chk("after collide doutb", doutb_w[0], 32'h11BB33DD);

      // Back-to-back stream on port B.
      for (int i = 0; i < 8; i++) cyc(1, 4'hF, AW'(i), i * 32'h01010101, 0, 8'h00);
      for (int i = 0; i < 8; i++) begin
         cyc(0, 4'h0, 8'h00, 32'h0, 1, AW'(i));
         chk("stream doutb", doutb_w[0], i * 32'h01010101);
      end

      // Single read then idle: dout holds, rvalid pulses once.
      cyc(0, 4'h0, 8'h00, 32'h0, 1, 8'h05);
      for (int i = 0; i < 3; i++) begin
         cyc(0, 4'h0, 8'h00, 32'h0, 0, 8'h00);
         chk("hold doutb", doutb_w[0], 32'h05050505);
      end

      // Reset while a latency-2 read is in flight, with a write that must be dropped.
      cyc(0, 4'h0, 8'h00, 32'h0, 1, 8'h05);
      rstn = 1'b0;
      cyc(1, 4'hF, 8'h30, 32'hCAFEF00D, 0, 8'h00);
      rstn = 1'b1;
      chk("drop doutb", doutb_w[2], 32'h0);
      cyc(0, 4'h0, 8'h00, 32'h0, 0, 8'h00);
      chk("drop rvalidb", {31'b0, rvalidb_w[2]}, 32'h0);
      cyc(0, 4'h0, 8'h00, 32'h0, 1, 8'h30);
      cyc(0, 4'h0, 8'h00, 32'h0, 0, 8'h00);

      // Extremes of the address range.
      cyc(1, 4'hF, 8'hFF, 32'hA5A5C3C3, 0, 8'h00);
      cyc(1, 4'hF, 8'h00, 32'h5A5A3C3C, 0, 8'h00);
      cyc(1, 4'h0, 8'hFF, 32'h0, 1, 8'h00);
      chk("last addr douta", douta_w[0], 32'hA5A5C3C3);
      chk("addr0 doutb", doutb_w[0], 32'h5A5A3C3C);
      cyc(0, 4'h0, 8'h00, 32'h0, 0, 8'h00);

      // Random traffic, biased toward a few addresses to force collisions.
      for (int n = 0; n < 600; n++) begin
         rstn = ($urandom_range(0, 49) != 0);
         ra = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 3)) : AW'($urandom);
         rb = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 3)) : AW'($urandom);
         cyc(bit'($urandom_range(0, 1)), 4'($urandom), ra, $urandom,
             bit'($urandom_range(0, 1)), rb);
      end
      rstn = 1'b1;
      for (int i = 0; i < 3; i++) cyc(0, 4'h0, 8'h00, 32'h0, 0, 8'h00);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/dcache_bram_dp.md
Name: dcache_bram_dp

Overview:
- Parametrised true-read / single-write dual-port block RAM for the Dcache data and tag arrays.
- Port A reads and writes with byte-enables; port B is read-only.
- Adds a configurable read latency (optional output register), per-port read-valid tracking, and a defined read-during-write / cross-port collision policy with byte-merge forwarding.
- Replaces the bare two-port bram instance used for early Dcache bring-up.

Parameters:
- DATA_WIDTH, 32, word width in bits; must be a multiple of 8.
- ADDR_WIDTH, 8, address width; depth = 2**ADDR_WIDTH words.
- OUT_REG, 0, 0 gives read latency 1; 1 adds an output register, giving latency 2.
- RDW_MODE, 1, 1 = write-first (a read returns the byte-merged new data); 0 = read-first (returns the old word).

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rstn  in  1  synchronous, active-low reset.
- ena  in  1  port A access enable.
- wea  in  DATA_WIDTH/8  port A byte write enables; ignored unless ena=1.
- addra  in  ADDR_WIDTH  port A word address.
- dina  in  DATA_WIDTH  port A write data.
- douta  out  DATA_WIDTH  port A read data.
- rvalida  out  1  douta holds the result of a port A access issued 1+OUT_REG cycles earlier.
- enb  in  1  port B read enable.
- addrb  in  ADDR_WIDTH  port B word address.
- doutb  out  DATA_WIDTH  port B read data.
- rvalidb  out  1  doutb holds the result of a port B read issued 1+OUT_REG cycles earlier.

Behaviour:
- Reset (rstn=0 at a clk edge):
  - douta, doutb, rvalida, rvalidb and all pipeline registers clear to 0.
  - Memory contents are not cleared.
  - Writes presented in a cycle with rstn=0 are suppressed.
  - In-flight reads are dropped: rvalid stays 0 and no stale data appears after reset deasserts.
- Port A write: at the edge with ena=1, rstn=1, each byte i with wea[i]=1 takes dina[8i+7:8i]. Bytes with wea[i]=0 are unchanged.
- Port A read: every cycle with ena=1 is also a read of addra. With wea=0 it is a pure read.
  - RDW_MODE=1: returned word = old word with the enabled bytes replaced by dina.
  - RDW_MODE=0: returned word = old word.
- Port B read: with enb=1, addrb is sampled.
  - If ena=1, wea!=0 and addra==addrb in the same cycle, the collision follows RDW_MODE exactly as for port A: merged new data or old data. Never X, never a partial mix.
  - This forwarding is explicit logic, not left to synthesis.
- Latency:
  - OUT_REG=0: data and rvalid appear on the cycle after the request.
  - OUT_REG=1: they appear two cycles after the request.
  - The pipeline is fully throughput-1: back-to-back requests return back-to-back data.
- Hold: when a port issues no request, dout holds its last returned value and rvalid deasserts for the corresponding cycle. Downstream may sample dout without re-reading.
- Write-then-read, same address, consecutive cycles: the read sees the written data in both modes.
- Address wrap: addresses are a full ADDR_WIDTH. No bounds check is needed; depth is exactly a power of two.
- Both ports reading the same address in the same cycle with no write: identical data, same cycle.

Decomposition:
- Package dcache_pkg holds:
  - byte-lane helper function merge_bytes(old, new, be);
  - localparams LAT_1 / LAT_2 and RDW_READ_FIRST / RDW_WRITE_FIRST.
- One natural sub-module: dcache_bram_rdpipe, the per-port read pipeline. It covers the optional output register, rvalid shift, and hold-last-value logic, and is instantiated once per port.
- The array plus collision forwarding stays in the top module.

Test Plan:
- Reset, then write 0xDEADBEEF to addr 0x10 (wea=4'hF), then read on both ports the next cycle -> douta=doutb=0xDEADBEEF with rvalid=1 after 1 cycle (OUT_REG=0) and after 2 cycles (OUT_REG=1).
- mem[0x20]=0x11223344. Same-cycle write dina=0xAABBCCDD, wea=4'b0101 to 0x20 while port B reads 0x20:
  - RDW_MODE=1 -> doutb=0x11BB33DD.
  - RDW_MODE=0 -> doutb=0x11223344.
  - Next read of 0x20 -> 0x11BB33DD.
- Stream reads 0x00..0x07 back-to-back on port B after preloading mem[i]=i*0x01010101 -> eight consecutive rvalidb=1 cycles with the matching data, no bubbles.
- Read 0x05 and then idle for 3 cycles -> doutb holds mem[5], rvalidb=1 for exactly one cycle.
- Issue a read with OUT_REG=1 and pull rstn low on the following cycle, together with a write to 0x30 -> doutb=0, rvalidb never asserts for the dropped read, and mem[0x30] is unchanged.
- Write to the last address 2**ADDR_WIDTH-1 and to 0 -> both read back correctly, with no aliasing.
